// File: rtl/huffman_bit_encoder_if.sv
// Symbol-store read port and serial bit stream between the encoder and its neighbours.
// master = encoder side, slave = store/sink side.
interface huffman_bit_encoder_if #(
  parameter int PTR_W = 9
);
  logic [PTR_W-1:0] data_point;
  logic [3:0]       data_in;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;

  modport master (
    output data_point,
    input  data_in,
    output bit_out,
    output bit_valid,
    input  bit_ready
  );

  modport slave (
    input  data_point,
    output data_in,
    input  bit_out,
    input  bit_valid,
    output bit_ready
  );
endinterface

// File: rtl/huffman_bit_encoder.sv
// Walks the stored symbols in order and serialises each symbol's Huffman code, MSB first,
// one bit per valid/ready transfer, with a running bit count and a sticky malformed-input flag.
module huffman_bit_encoder #(
  parameter int NUM_SYMBOLS = 256,
  parameter int PTR_W       = 9,
  parameter int MAX_LEN     = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [89:0]           code_flat,
  input  logic [39:0]           len_flat,
  huffman_bit_encoder_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [11:0]           bit_count,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_SYMBOLS - 1);
  localparam logic [3:0]       MAX_LEN_C = 4'(MAX_LEN);

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [8:0]       shreg, shreg_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [11:0]      count_nxt;
  logic             err_nxt;

  logic [8:0]       code_tab [10];
  logic [3:0]       len_tab  [10];
  logic             sym_bad;
  logic [3:0]       sym;
  logic [3:0]       sym_len;

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      code_tab[k] = code_flat[9*k +: 9];
      len_tab[k]  = len_flat[4*k +: 4];
    end
  end

  // Out-of-alphabet symbols fall back to symbol 0, the upstream counter's default bin.
  always_comb begin
    sym_bad = (bus.data_in > 4'd9);
    sym     = sym_bad ? 4'd0 : bus.data_in;
    sym_len = len_tab[sym];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      bit_count <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      bit_count <= count_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    count_nxt = bit_count;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          ptr_nxt   = '0;
          count_nxt = '0;
          err_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        shreg_nxt = code_tab[sym];
        cnt_nxt   = sym_len;
        if (sym_bad) err_nxt = 1'b1;
        // A zero-length code emits nothing, so skip straight to the next symbol.
        if (sym_len == 4'd0) begin
          err_nxt = 1'b1;
          if (ptr == LAST_PTR) state_nxt = DONE;
          else                 ptr_nxt   = ptr + 1'b1;
        end else begin
          if (sym_len > MAX_LEN_C) begin
            err_nxt = 1'b1;
            cnt_nxt = MAX_LEN_C;
          end
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_ready) begin
          cnt_nxt   = cnt - 4'd1;
          count_nxt = bit_count + 12'd1;
          if (cnt == 4'd1) begin
            if (ptr == LAST_PTR) begin
              state_nxt = DONE;
            end else begin
              ptr_nxt   = ptr + 1'b1;
              state_nxt = FETCH;
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data_point = ptr;
  assign bus.bit_valid  = (state == SHIFT);
  assign bus.bit_out    = (state == SHIFT) ? shreg[cnt - 4'd1] : 1'b0;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_huffman_bit_encoder.sv
// Scoreboard bench: a reference model queues the expected bit stream per run and each
// accepted DUT bit is popped and compared; counts, flags and timing are checked at the end.
module tb_huffman_bit_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [89:0] code_flat;
  logic [39:0] len_flat;
  logic        busy, done, err;
  logic [11:0] bit_count;

  huffman_bit_encoder_if #(.PTR_W(9)) sif ();

  huffman_bit_encoder #(.NUM_SYMBOLS(256), .PTR_W(9), .MAX_LEN(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .code_flat (code_flat),
    .len_flat  (len_flat),
    .bus       (sif.master),
    .busy      (busy),
    .done      (done),
    .bit_count (bit_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [256];
  logic [8:0] code_t [10];
  logic [3:0] len_t [10];
  bit         exp_q [$];
  int         exp_bits;
  bit         exp_err;
  int         n_cmp = 0;
  int         n_err = 0;

  // Symbol store model: combinational read at the DUT pointer.
  assign sif.data_in = mem[sif.data_point[7:0]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic setDefaultTables();
    for (int k = 0; k < 10; k++) begin
      len_t[k]  = (k == 0) ? 4'd1 : 4'(k);
      code_t[k] = 9'((k * 11 + 5) & ((1 << len_t[k]) - 1));
    end
  endtask

  task automatic packTables();
    for (int k = 0; k < 10; k++) begin
      code_flat[9*k +: 9] = code_t[k];
      len_flat[4*k +: 4]  = len_t[k];
    end
  endtask

  // Reference model of the whole stream for the current memory and tables.
  task automatic buildExpected();
    int s;
    int l;
    exp_q.delete();
    exp_bits = 0;
    exp_err  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      s = int'(mem[i]);
      if (s > 9) begin
        exp_err = 1'b1;
        s = 0;
      end
      l = int'(len_t[s]);
      if (l == 0) exp_err = 1'b1;
      if (l > 9) begin
        exp_err = 1'b1;
        l = 9;
      end
      for (int b = l - 1; b >= 0; b--) begin
        exp_q.push_back(code_t[s][b]);
        exp_bits++;
      end
    end
  endtask

  task automatic applyStimulus(input bit rand_ready, input bit poke_start,
                               output int first_valid, output int done_at);
    int  done_cnt;
    bit  stalled;
    first_valid = -1;
    done_at     = -1;
    done_cnt    = 0;
    stalled     = 1'b0;
    packTables();
    buildExpected();
    @(negedge clk);
    start = 1'b1;
    sif.bit_ready = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = poke_start && (cyc == 50 || done);
      sif.bit_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) checkOutput("busy_rise", busy, 1);
      if (stalled) checkOutput("valid_hold", sif.bit_valid, 1);
      stalled = sif.bit_valid && !sif.bit_ready;
      if (sif.bit_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("extra_bit", sif.bit_valid, 0);
        end else begin
          checkOutput("bit", sif.bit_out, exp_q[0]);
          if (sif.bit_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    start = 1'b0;
    if (done_at < 0) checkOutput("done_timeout", done, 1);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("bits_left", exp_q.size(), 0);
    checkOutput("busy_fall", busy, 0);
    checkOutput("final_ptr", sif.data_point, 255);
    checkOutput("bit_count", bit_count, exp_bits);
    checkOutput("err", err, exp_err);
  endtask

  initial begin
    int fv;
    int da;
    int hit;
    rst_n = 1'b0;
    start = 1'b0;
    sif.bit_ready = 1'b0;
    code_flat = '0;
    len_flat = '0;
    for (int i = 0; i < 256; i++) mem[i] = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_ptr", sif.data_point, 0);
    checkOutput("rst_valid", sif.bit_valid, 0);
    checkOutput("rst_bit", sif.bit_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_count", bit_count, 0);
    checkOutput("rst_err", err, 0);
    rst_n = 1'b1;

    $display("[TB] all symbols 3, code 10, ready held high");
    setDefaultTables();
    len_t[3] = 4'd2;
    code_t[3] = 9'b10;
    for (int i = 0; i < 256; i++) mem[i] = 4'd3;
    applyStimulus(1'b0, 1'b0, fv, da);
    checkOutput("t1_count", bit_count, 512);
    checkOutput("t1_err", err, 0);
    checkOutput("t1_done_lat", da - fv + 1, 768);

    $display("[TB] symbols cycling 0..9, random ready");
    setDefaultTables();
    for (int i = 0; i < 256; i++) mem[i] = 4'(i % 10);
    applyStimulus(1'b1, 1'b0, fv, da);
    checkOutput("t2_err", err, 0);

    $display("[TB] out-of-range symbol at index 5");
    setDefaultTables();
    len_t[0] = 4'd3;
    code_t[0] = 9'b011;
    for (int i = 0; i < 256; i++) mem[i] = 4'(i % 10);
    mem[5] = 4'd12;
    applyStimulus(1'b1, 1'b0, fv, da);
    checkOutput("t3_err", err, 1);

    $display("[TB] zero-length code on symbol 7");
    setDefaultTables();
    len_t[7] = 4'd0;
    len_t[1] = 4'd3;
    code_t[1] = 9'b101;
    for (int i = 0; i < 256; i++) mem[i] = (i < 10) ? 4'd7 : 4'd1;
    applyStimulus(1'b0, 1'b0, fv, da);
    checkOutput("t4_count", bit_count, 738);
    checkOutput("t4_err", err, 1);

    $display("[TB] reset mid-shift at symbol 100");
    setDefaultTables();
    for (int i = 0; i < 256; i++) mem[i] = 4'(i % 10);
    mem[3] = 4'd15;
    for (int i = 95; i < 105; i++) mem[i] = 4'd9;
    packTables();
    @(negedge clk);
    start = 1'b1;
    sif.bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int cyc = 0; cyc < 5000 && hit == 0; cyc++) begin
      @(negedge clk);
      #1;
      if (sif.data_point == 9'd100 && sif.bit_valid) hit = 1;
    end
    if (hit == 0) checkOutput("reach_sym100", sif.data_point, 100);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid_rst_ptr", sif.data_point, 0);
    checkOutput("mid_rst_valid", sif.bit_valid, 0);
    checkOutput("mid_rst_bit", sif.bit_out, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_count", bit_count, 0);
    checkOutput("mid_rst_err", err, 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, fv, da);

    $display("[TB] extra start during busy and done");
    setDefaultTables();
    for (int i = 0; i < 256; i++) mem[i] = 4'((i * 7) % 10);
    applyStimulus(1'b1, 1'b1, fv, da);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t6_idle_busy", busy, 0);
    checkOutput("t6_count_kept", bit_count, exp_bits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
